// File: rtl/two_digit_display_driver_pkg.sv
// Shared types and constants for the two-digit multiplexed display driver.
// Segment patterns come from the common seg7 include.
`include "seg7_defs.vh"

package two_digit_display_driver_pkg;

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_e;

    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

    localparam logic [6:0] SEG_BLANK = `SEG7_BLANK;

endpackage

// File: rtl/seg7_defs.vh
// Seven-segment pattern constants, active-low {g,f,e,d,c,b,a}.
// Shared by all display blocks in this codebase.
`ifndef SEG7_DEFS_VH
`define SEG7_DEFS_VH

`define SEG7_0     7'b1000000
`define SEG7_1     7'b1111001
`define SEG7_2     7'b0100100
`define SEG7_3     7'b0110000
`define SEG7_4     7'b0011001
`define SEG7_5     7'b0010010
`define SEG7_6     7'b0000010
`define SEG7_7     7'b1111000
`define SEG7_8     7'b0000000
`define SEG7_9     7'b0010000
`define SEG7_DASH  7'b0111111
`define SEG7_BLANK 7'b1111111

`endif

// File: rtl/two_digit_display_driver_bcd_to_seg7.sv
// BCD to active-low seven-segment decoder.
// Non-BCD codes 10..15 show a dash.
`include "seg7_defs.vh"

module bcd_to_seg7 (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Pure table lookup; anything outside 0..9 falls through to the dash
    always_comb begin
        seg_o = `SEG7_DASH;
        case (bcd_i)
            4'd0:    seg_o = `SEG7_0;
            4'd1:    seg_o = `SEG7_1;
            4'd2:    seg_o = `SEG7_2;
            4'd3:    seg_o = `SEG7_3;
            4'd4:    seg_o = `SEG7_4;
            4'd5:    seg_o = `SEG7_5;
            4'd6:    seg_o = `SEG7_6;
            4'd7:    seg_o = `SEG7_7;
            4'd8:    seg_o = `SEG7_8;
            4'd9:    seg_o = `SEG7_9;
            default: seg_o = `SEG7_DASH;
        endcase
    end

endmodule

// File: rtl/two_digit_display_driver.sv
// Two-digit multiplexed seven-segment driver with frame-start shadowing
// and optional leading-zero blanking. Outputs are registered.
module two_digit_display_driver
    import two_digit_display_driver_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       Clk,
    input  logic       R,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    output logic [6:0] SEG,
    output logic [1:0] AN
);

    localparam int          CW   = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    slot_e         sel_q, sel_d;
    logic [3:0]    s0_q, s0_d;
    logic [3:0]    s1_q, s1_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;

    logic          tick;
    logic [3:0]    dig;
    logic [6:0]    dig_seg;
    logic          blank;

    // Decoder sees the digit that will be on the pins next cycle
    bcd_to_seg7 u_dec (
        .bcd_i (dig),
        .seg_o (dig_seg)
    );

    // Next-state: prescaler, slot toggle, frame-start capture, pin values
    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        sel_d = sel_q;
        s0_d  = s0_q;
        s1_d  = s1_q;
        if (tick) begin
            sel_d = (sel_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
            if (sel_q == SLOT_TENS) begin
                s0_d = D0;
                s1_d = D1;
            end
        end
        dig   = (sel_d == SLOT_TENS) ? s1_d : s0_d;
        blank = BLANK_LZ && (sel_d == SLOT_TENS) && (s1_d == 4'd0);
        an_d  = (sel_d == SLOT_TENS) ? AN_TENS : AN_ONES;
        seg_d = dig_seg;
        if (blank) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (R) begin
            cnt_q <= '0;
            sel_q <= SLOT_ONES;
            s0_q  <= 4'd0;
            s1_q  <= 4'd0;
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
            s0_q  <= s0_d;
            s1_q  <= s1_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign SEG = seg_q;
    assign AN  = an_q;

endmodule

// File: doc/two_digit_display_driver.md
TWO_DIGIT_DISPLAY_DRIVER -- requirements
Module: two_digit_display_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000: Clk cycles per digit slot; legal range is 2 or greater.
REQ-002 Parameter BLANK_LZ, default 1: when set to 1, blank the tens digit when it is zero.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 R  input  1  synchronous, active-high reset.
REQ-005 D0  input  4  BCD ones digit, as produced by the team's counter blocks.
REQ-006 D1  input  4  BCD tens digit.
REQ-007 SEG  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-008 AN  output  2  active-low digit enables; AN[0] is ones, AN[1] is tens.

Function
REQ-009 Prescaler counts 0..SCAN_DIV-1 and wraps to 0.
- The scan tick is asserted in the cycle where prescaler == SCAN_DIV-1.
REQ-010 A 1-bit digit-select state sel toggles on each tick.
- sel=0 selects the ones slot; sel=1 selects the tens slot.
REQ-011 Shadow registers S0/S1 capture D0/D1 only on a tick where sel changes from 1 to 0 (frame start).
- D0/D1 changes at other times have no effect until the next frame start, so no tearing.
REQ-012 SEG and AN are registered.
- Each cycle they are loaded from the next-cycle sel and shadow values.
- Latency from sel/shadow update to pin is exactly 1 cycle.
REQ-013 When sel=0: AN=2'b10 and SEG=decode(S0).
REQ-014 When sel=1: AN=2'b01 and SEG=decode(S1).
- Exception: if BLANK_LZ=1 and S1==0, then AN=2'b11 and SEG=7'b1111111.
REQ-015 Decode patterns, active-low {g..a}:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-016 Non-BCD input values 10..15 decode to a dash, 0111111 (segment g only).
REQ-017 AN never has both bits low in any cycle.
REQ-018 Each slot lasts exactly SCAN_DIV cycles; one full frame is 2*SCAN_DIV cycles.

Reset
REQ-019 While R=1 at a rising edge:
- prescaler=0, sel=0, S0=S1=0
- AN=2'b11, SEG=7'b1111111
REQ-020 In the first cycle after R deasserts, outputs show AN=2'b10, SEG=1000000 (ones digit "0").
- The first capture of D0/D1 occurs at the first 1-to-0 toggle, 2*SCAN_DIV cycles after reset release.
REQ-021 Asserting R mid-slot or mid-frame aborts the scan immediately.
- Outputs and state return to the REQ-019 values at that edge.
- No partial frame resumes after release.

Structure
REQ-022 The seven-segment pattern constants (REQ-015, REQ-016) and the blank pattern live in a shared include file, seg7_defs.vh.
- The team's other display blocks reuse that file.
REQ-023 One combinational sub-module, bcd_to_seg7 (4-bit in, 7-bit active-low out), implements decode.
- It is instantiated once, fed by a mux of S0/S1 selected by the next sel.
REQ-024 Prescaler width is the minimum that holds SCAN_DIV-1; no other clock or clock enable is generated.

Verification (SCAN_DIV=4 unless stated)
REQ-025 Scan timing:
- Stimulus: R=1 for 3 cycles, then release with D0=3, D1=7.
- Required: AN=10/SEG=1000000 for 4 cycles, then AN=01/SEG=1000000 blanked to AN=11 (S1=0 with BLANK_LZ=1), then AN=10/SEG=0110000.
- After that the slots alternate 3 and 7 every 4 cycles.
REQ-026 Tearing:
- Stimulus: change D0 from 3 to 5 in the middle of the tens slot.
- Required: ones slot still shows 3 until the next frame start, then shows 0010010.
REQ-027 Leading zero:
- Stimulus: D1=0, D0=8 with BLANK_LZ=1.
- Required: tens slot gives AN=11, SEG=1111111.
- Repeat with BLANK_LZ=0: tens slot gives AN=01, SEG=1000000.
REQ-028 Invalid BCD:
- Stimulus: D0=12, D1=15.
- Required: both slots show 0111111 with the normal AN pattern.
REQ-029 Mid-operation reset:
- Stimulus: assert R for 1 cycle in the middle of the tens slot.
- Required: AN=11/SEG=1111111 at the next edge, then the REQ-020 sequence; AN never reads 00.
REQ-030 Soak test:
- Stimulus: drive D1:D0 from a counter_1digit pair for 1000 frames.
- Required: each frame displays the values latched at frame start, and the slot length is always exactly SCAN_DIV cycles.
